delay_sched: RTL and testbench

DELAY_SCHED -- requirements
Module: delay_sched

---
 rtl/delay_sched.sv | 179 +++++++++++++++++
 tb/tb_delay_sched.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/delay_sched.sv
// -----------------------------------------------------------------------------
// delay_sched -- shared delay counter with round-robin arbitration.
//
// Several requesters share one delay counter. While idle, the block picks a
// winner round-robin, starting the search at the rotating pointer. A winner
// with a legal delay (1..MAXDLY) owns the counter for exactly that many
// cycles. The owner then gets a one-cycle done pulse. A winner with an
// illegal delay (0 or above MAXDLY) is rejected: it gets done together with
// err, and is never granted.
//
// Ports
//   clk   : sole clock, every state change on its rising edge
//   rst   : synchronous, active-high reset
//   req   : [NREQ] level requests, held until done (or abort)
//   dly   : [NREQ*CBITS] per-requester delays, slice i = dly[i*CBITS +: CBITS]
//   gnt   : [NREQ] one-hot current owner of the counter, zero when no owner
//   done  : [NREQ] one-cycle completion pulse to the owner
//   err   : one-cycle pulse flagging a rejected request
//   busy  : high while the counter is owned
//   cnt   : [CBITS] current count, zero when the counter is not owned
//
// Optional feature
//   DELAY_SCHED_ABORT_EN : when defined, the owner dropping its req while it
//   holds the counter abandons the run immediately. There is no done and no
//   err for that run. When undefined, such a drop is ignored.
// -----------------------------------------------------------------------------
module delay_sched #(
    parameter int NREQ   = 4,
    parameter int CBITS  = 10,
    parameter int MAXDLY = 750
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*CBITS-1:0] dly,
    output logic [NREQ-1:0]       gnt,
    output logic [NREQ-1:0]       done,
    output logic                  err,
    output logic                  busy,
    output logic [CBITS-1:0]      cnt
);

    localparam int WBITS = (NREQ > 1) ? $clog2(NREQ) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [WBITS:0]   NREQ_W = (WBITS+1)'(NREQ);
    localparam logic [CBITS-1:0] MAX_C  = CBITS'(MAXDLY);

    logic [1:0]       state_reg, state_next;
    logic [WBITS-1:0] owner_reg, owner_next;
    logic [WBITS-1:0] ptr_reg,   ptr_next;
    logic [CBITS-1:0] dl_reg,    dl_next;
    logic [CBITS-1:0] cnt_reg,   cnt_next;
    logic             err_reg,   err_next;

    // Unpack the flat delay bus into one entry per requester.
    logic [CBITS-1:0] dly_arr [NREQ];
    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_unpack
            assign dly_arr[gi] = dly[gi*CBITS +: CBITS];
        end
    endgenerate

    // Round-robin search. Rotate req so that bit 0 is the requester at ptr.
    // The lowest set bit of the rotated vector then gives the offset of the
    // winner from ptr.
    logic [2*NREQ-1:0] req_dbl;
    logic [NREQ-1:0]   req_rot;
    logic              win_found;
    logic [WBITS-1:0]  win_off;
    logic [WBITS:0]    win_sum;
    logic [WBITS-1:0]  win_idx;
    logic [WBITS:0]    ptr_inc;
    logic [CBITS-1:0]  dly_win;
    logic              dly_ok;

    assign req_dbl = {req, req};
    assign req_rot = req_dbl[ptr_reg +: NREQ];

    always_comb begin
        win_found = 1'b0;
        win_off   = '0;
        // Descending scan so that the lowest offset is the last one written.
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req_rot[k]) begin
                win_found = 1'b1;
                win_off   = WBITS'(k);
            end
        end
    end

    assign win_sum = {1'b0, ptr_reg} + {1'b0, win_off};
    assign win_idx = (win_sum >= NREQ_W) ? WBITS'(win_sum - NREQ_W) : WBITS'(win_sum);
    assign ptr_inc = {1'b0, win_idx} + {{WBITS{1'b0}}, 1'b1};
    assign dly_win = dly_arr[win_idx];
    assign dly_ok  = (dly_win != '0) && (dly_win <= MAX_C);

    always_comb begin
        state_next = state_reg;
        owner_next = owner_reg;
        ptr_next   = ptr_reg;
        dl_next    = dl_reg;
        cnt_next   = cnt_reg;
        err_next   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (win_found) begin
                    owner_next = win_idx;
                    // The pointer advances on every pick, accepted or rejected.
                    ptr_next   = (ptr_inc == NREQ_W) ? '0 : WBITS'(ptr_inc);
                    cnt_next   = '0;
                    if (dly_ok) begin
                        state_next = RUN;
                        dl_next    = dly_win;
                    end else begin
                        state_next = DONE;
                        err_next   = 1'b1;
                    end
                end
            end
            RUN: begin
`ifdef DELAY_SCHED_ABORT_EN
                if (!req[owner_reg]) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else
`endif
                if (cnt_reg == dl_reg - CBITS'(1)) begin
                    state_next = DONE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + CBITS'(1);
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            owner_reg <= '0;
            ptr_reg   <= '0;
            dl_reg    <= '0;
            cnt_reg   <= '0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            owner_reg <= owner_next;
            ptr_reg   <= ptr_next;
            dl_reg    <= dl_next;
            cnt_reg   <= cnt_next;
            err_reg   <= err_next;
        end
    end

    // Outputs are decoded only from registered state.
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_onehot
            assign gnt[gi]  = (state_reg == RUN)  && (owner_reg == WBITS'(gi));
            assign done[gi] = (state_reg == DONE) && (owner_reg == WBITS'(gi));
        end
    endgenerate

    assign busy = (state_reg == RUN);
    assign err  = err_reg;
    assign cnt  = cnt_reg;

endmodule

// File: tb/tb_delay_sched.sv
// -----------------------------------------------------------------------------
// tb_delay_sched -- self-checking bench for delay_sched.
//
// The reference model follows each request as a whole transaction. It tracks
// the owner, the number of grant cycles still left, and whether a completion
// is pending. Every cycle it predicts gnt, done, err, busy and cnt.
// Directed scenarios come first, followed by a randomized request mix.
// -----------------------------------------------------------------------------
module tb_delay_sched;

    localparam int NREQ   = 4;
    localparam int CBITS  = 10;
    localparam int MAXDLY = 750;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NREQ-1:0]       req;
    logic [NREQ*CBITS-1:0] dly;
    logic [NREQ-1:0]       gnt;
    logic [NREQ-1:0]       done;
    logic                  err;
    logic                  busy;
    logic [CBITS-1:0]      cnt;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int m_left;   // grant cycles still to show (0 when no owner)
    int m_len;    // accepted delay of the current run
    int m_owner;
    int m_ptr;
    bit m_done;   // completion visible this cycle
    bit m_err;

    delay_sched #(.NREQ(NREQ), .CBITS(CBITS), .MAXDLY(MAXDLY)) dut (
        .clk  (clk),
        .rst  (rst),
        .req  (req),
        .dly  (dly),
        .gnt  (gnt),
        .done (done),
        .err  (err),
        .busy (busy),
        .cnt  (cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_dly(input int i, input int v);
        dly[i*CBITS +: CBITS] = CBITS'(v);
    endtask

    task automatic model_step(input bit r, input logic [NREQ-1:0] q, input logic [NREQ*CBITS-1:0] d);
        int dv;
        bit ab;
        if (r) begin
            m_left = 0; m_len = 0; m_owner = 0; m_ptr = 0; m_done = 0; m_err = 0;
        end else if (m_done) begin
            m_done = 0;
            m_err  = 0;
        end else if (m_left > 0) begin
            ab = 1'b0;
`ifdef DELAY_SCHED_ABORT_EN
            ab = !q[m_owner];
`endif
            if (ab) begin
                m_left = 0;
            end else begin
                m_left--;
                if (m_left == 0) m_done = 1;
            end
        end else if (q != '0) begin
            for (int k = 0; k < NREQ; k++) begin
                if (q[(m_ptr + k) % NREQ]) begin
                    m_owner = (m_ptr + k) % NREQ;
                    break;
                end
            end
            m_ptr = (m_owner + 1) % NREQ;
            dv = int'(d[m_owner*CBITS +: CBITS]);
            if (dv >= 1 && dv <= MAXDLY) begin
                m_left = dv;
                m_len  = dv;
            end else begin
                m_done = 1;
                m_err  = 1;
            end
        end
    endtask

    // One clock: capture inputs, advance the model at the edge, then compare.
    task automatic tick();
        bit r;
        logic [NREQ-1:0] q;
        logic [NREQ*CBITS-1:0] d;
        logic [31:0] eg, ed;
        r = rst; q = req; d = dly;
        @(posedge clk);
        #1;
        model_step(r, q, d);
        eg = (m_left > 0) ? (32'd1 << m_owner) : 32'd0;
        ed = m_done ? (32'd1 << m_owner) : 32'd0;
        check("gnt",  32'(gnt),  eg);
        check("done", 32'(done), ed);
        check("err",  32'(err),  32'(m_err));
        check("busy", 32'(busy), 32'(m_left > 0));
        check("cnt",  32'(cnt),  (m_left > 0) ? 32'(m_len - m_left) : 32'd0);
    endtask

    // Run until cnt reaches target; a missed target counts as a failure.
    task automatic wait_cnt(input string tag, input int target, input int maxc);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < maxc && !hit; i++) begin
            tick();
            if (busy && int'(cnt) == target) hit = 1'b1;
        end
        check(tag, 32'(hit), 32'd1);
    endtask

    // Requesters drop their req on seeing done; continue until all is quiet.
    task automatic drain(input string tag, input int maxc);
        bit quiet;
        quiet = 1'b0;
        for (int i = 0; i < maxc && !quiet; i++) begin
            tick();
            req = req & ~done;
            if (req == '0 && !busy && done == '0) quiet = 1'b1;
        end
        check(tag, 32'(quiet), 32'd1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        int ncyc, maxc;
        bit seen_done;
        rst = 1'b1;
        req = '0;
        dly = '0;
        m_left = 0; m_len = 0; m_owner = 0; m_ptr = 0; m_done = 0; m_err = 0;

        // Reset state
        tick();
        tick();
        check("rst_gnt",  32'(gnt),  32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_cnt",  32'(cnt),  32'd0);
        rst = 1'b0;

        // Single request, dly=3
        req = 4'b0001;
        set_dly(0, 3);
        tick();
        check("single_gnt_first", 32'(gnt), 32'h1);
        tick();
        tick();
        check("single_gnt_last", 32'(gnt), 32'h1);
        tick();
        check("single_done", 32'(done), 32'h1);
        check("single_err", 32'(err), 32'd0);
        req = '0;
        tick();

        // Round-robin order 0,1,2,3,0 with every dly=2
        do_reset();
        for (int i = 0; i < NREQ; i++) set_dly(i, 2);
        req = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            tick();
            check("rr_gnt", 32'(gnt), 32'd1 << (g % NREQ));
            tick();
            tick();
            check("rr_done", 32'(done), 32'd1 << (g % NREQ));
            tick();
        end
        req = '0;
        tick();

        // Invalid delays 0 and 751 on requester 2; the pointer then moves to 3
        do_reset();
        req = 4'b0100;
        set_dly(2, 0);
        tick();
        check("inv0_err",  32'(err),  32'd1);
        check("inv0_done", 32'(done), 32'h4);
        check("inv0_gnt",  32'(gnt),  32'd0);
        tick();
        set_dly(2, 751);
        tick();
        check("inv751_err",  32'(err),  32'd1);
        check("inv751_done", 32'(done), 32'h4);
        req = '0;
        tick();
        for (int i = 0; i < NREQ; i++) set_dly(i, 1);
        req = 4'b1111;
        tick();
        check("inv_ptr3", 32'(gnt), 32'h8);
        req = 4'b1000;
        drain("inv_drain", 20);

        // Maximum delay on requester 1
        req = 4'b0010;
        set_dly(1, MAXDLY);
        ncyc = 0; maxc = 0; seen_done = 1'b0;
        for (int i = 0; i < MAXDLY + 20 && !seen_done; i++) begin
            tick();
            if (gnt == 4'b0010) ncyc++;
            if (int'(cnt) > maxc) maxc = int'(cnt);
            if (done != '0) begin
                seen_done = 1'b1;
                check("max_done", 32'(done), 32'h2);
            end
        end
        check("max_gnt_cycles", 32'(ncyc), 32'(MAXDLY));
        check("max_cnt_peak",   32'(maxc), 32'(MAXDLY - 1));
        check("max_seen_done",  32'(seen_done), 32'd1);
        req = '0;
        tick();

        // Reset in the middle of a run; the pending req restarts from ptr=0
        req = 4'b0010;
        set_dly(1, 10);
        wait_cnt("midrst_reach5", 5, 30);
        rst = 1'b1;
        req = 4'b1010;
        tick();
        check("midrst_gnt",  32'(gnt),  32'd0);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_cnt",  32'(cnt),  32'd0);
        rst = 1'b0;
        set_dly(1, 3);
        set_dly(3, 2);
        tick();
        check("midrst_regrant", 32'(gnt), 32'h2);
        drain("midrst_drain", 40);

        // Owner drops its req at cnt=2 of a dly=8 run
        do_reset();
        req = 4'b1000;
        set_dly(3, 8);
        wait_cnt("abort_reach2", 2, 20);
        req = '0;
        tick();
`ifdef DELAY_SCHED_ABORT_EN
        check("abort_gnt",  32'(gnt),  32'd0);
        check("abort_done", 32'(done), 32'd0);
        tick();
        check("abort_quiet", 32'(done), 32'd0);
`else
        for (int i = 0; i < 4; i++) begin
            check("noabort_gnt", 32'(gnt), 32'h8);
            tick();
        end
        check("noabort_gnt_last", 32'(gnt), 32'h8);
        tick();
        check("noabort_done", 32'(done), 32'h8);
`endif
        tick();

        // Randomized traffic with delays changing every cycle
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                int r;
                r = int'($urandom_range(0, 63));
                if (r == 0)      set_dly(i, 0);
                else if (r == 1) set_dly(i, int'($urandom_range(MAXDLY + 1, (1 << CBITS) - 1)));
                else if (r == 2) set_dly(i, int'($urandom_range(40, 120)));
                else             set_dly(i, int'($urandom_range(1, 6)));
                if (done[i])                       req[i] = 1'b0;
                else if (!req[i])                  req[i] = ($urandom_range(0, 3) == 0);
                else if ($urandom_range(0, 31) == 0) req[i] = 1'b0;
            end
            rst = ($urandom_range(0, 299) == 0);
            tick();
        end
        rst = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
